vgroup_sequencer: RTL and testbench

- Parametrised successor to the LMUL grouping selector.
- Accepts one decoded vector ALU instruction per handshake: register specifiers, vtype fields and vl.
- Issues one register-granular micro-op per cycle over the register group, with register index offsets applied.
- Adds what the combinational selector lacked: registered sequencing, fractional-LMUL handling, vl-based early termination, widening mode, scalar-operand bypass and illegal-encoding detection.
- Sits between decode and the vector register-read stage. `lmul_stall` holds IF1/IF2 while a group is in flight.

---
 rtl/vrvv_pkg.sv | 34 +++
 rtl/vgroup_sequencer_if.sv | 36 +++
 rtl/vgroup_decode.sv | 61 ++++++
 rtl/vgroup_sequencer.sv | 104 ++++++++++
 tb/tb_vgroup_sequencer.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/vrvv_pkg.sv
// Shared vector-decode definitions: vtype encodings, sequencer states and
// group-size helpers used by the LMUL grouping sequencer.
package vrvv_pkg;

   localparam logic [2:0] LMUL_1   = 3'b000;
   localparam logic [2:0] LMUL_2   = 3'b001;
   localparam logic [2:0] LMUL_4   = 3'b010;
   localparam logic [2:0] LMUL_8   = 3'b011;
   localparam logic [2:0] LMUL_RSV = 3'b100;

   localparam logic [2:0] SEW_64   = 3'b011;

   typedef enum logic {
      IDLE  = 1'b0,
      ISSUE = 1'b1
   } seq_state_t;

   // Fractional and reserved codes collapse to a single register.
   function automatic logic [3:0] decode_lmul(input logic [2:0] vlmul);
      case (vlmul)
         LMUL_1:  return 4'd1;
         LMUL_2:  return 4'd2;
         LMUL_4:  return 4'd4;
         LMUL_8:  return 4'd8;
         default: return 4'd1;
      endcase
   endfunction

   function automatic int unsigned elems_per_reg(input logic [2:0] vsew,
                                                 input int unsigned vlen);
      return vlen >> (32'(vsew) + 32'd3);
   endfunction

endpackage

// File: rtl/vgroup_sequencer_if.sv
// Decode-side instruction handshake and register-read-side micro-op stream.
interface vgroup_sequencer_if #(
   parameter int unsigned REG_W = 5,
   parameter int unsigned VL_W  = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [REG_W-1:0] in_raA;
   logic [REG_W-1:0] in_raB;
   logic [REG_W-1:0] in_rdest;
   logic [2:0]       in_vlmul;
   logic [2:0]       in_vsew;
   logic [VL_W-1:0]  in_vl;
   logic             in_widen;
   logic             in_b_scalar;

   logic             uop_valid;
   logic             uop_ready;
   logic [REG_W-1:0] uop_raA;
   logic [REG_W-1:0] uop_raB;
   logic [REG_W-1:0] uop_rdest;
   logic [3:0]       uop_idx;
   logic             uop_last;

   modport master (
      output in_valid, in_raA, in_raB, in_rdest, in_vlmul, in_vsew, in_vl,
             in_widen, in_b_scalar, uop_ready,
      input  in_ready, uop_valid, uop_raA, uop_raB, uop_rdest, uop_idx, uop_last
   );

   modport slave (
      input  in_valid, in_raA, in_raB, in_rdest, in_vlmul, in_vsew, in_vl,
             in_widen, in_b_scalar, uop_ready,
      output in_ready, uop_valid, uop_raA, uop_raB, uop_rdest, uop_idx, uop_last
   );
endinterface

// File: rtl/vgroup_decode.sv
// Combinational group decode: micro-op count and illegal-encoding detection
// for one vector ALU instruction.
module vgroup_decode
   import vrvv_pkg::*;
#(
   parameter int unsigned VLEN     = 128,
   parameter int unsigned MAX_LMUL = 8,
   parameter int unsigned REG_W    = 5,
   parameter int unsigned VL_W     = 8
) (
   input  logic [REG_W-1:0] raA,
   input  logic [REG_W-1:0] raB,
   input  logic [REG_W-1:0] rdest,
   input  logic [2:0]       vlmul,
   input  logic [2:0]       vsew,
   input  logic [VL_W-1:0]  vl,
   input  logic             widen,
   input  logic             b_scalar,
   output logic [4:0]       n,
   output logic             illegal
);

   localparam int unsigned LOG2_VLEN = $clog2(VLEN);

   logic [3:0]       grp;
   logic [4:0]       emul_d;
   logic [2:0]       sew_eff;
   int unsigned      elems;
   logic [4:0]       shamt;
   logic [VL_W:0]    nvl;
   logic [REG_W-1:0] mask_g;
   logic [REG_W-1:0] mask_d;

   always_comb begin
      grp     = decode_lmul(vlmul);
      emul_d  = widen ? {grp, 1'b0} : {1'b0, grp};
      sew_eff = widen ? vsew + 3'd1 : vsew;
      elems   = elems_per_reg(sew_eff, VLEN);
      if (elems == 0) elems = 1;

      // elems is a power of two, so the ceiling divide reduces to a shift.
      shamt = '0;
      for (int unsigned k = 0; k <= LOG2_VLEN; k++) begin
         if (elems == (32'd1 << k)) shamt = 5'(k);
      end
      nvl = ({1'b0, vl} + (VL_W+1)'(elems - 1)) >> shamt;
      n   = (nvl > (VL_W+1)'(emul_d)) ? emul_d : nvl[4:0];

      mask_g = REG_W'(grp) - REG_W'(1);
      mask_d = REG_W'(emul_d) - REG_W'(1);

      illegal = (vlmul == LMUL_RSV)
              | (vsew > SEW_64)
              | (widen & ((vlmul == LMUL_8) | (vsew == SEW_64)))
              | (32'(grp) > MAX_LMUL)
              | (|(raA & mask_g))
              | (~b_scalar & (|(raB & mask_g)))
              | (|(rdest & mask_d));
   end

endmodule

// File: rtl/vgroup_sequencer.sv
// Register-group sequencer: accepts one decoded vector instruction and issues
// one register-granular micro-op per cycle with base offsets applied.
module vgroup_sequencer
   import vrvv_pkg::*;
#(
   parameter int unsigned VLEN     = 128,
   parameter int unsigned NREG     = 32,
   parameter int unsigned MAX_LMUL = 8,
   parameter int unsigned REG_W    = $clog2(NREG),
   parameter int unsigned VL_W     = $clog2(VLEN) + 1
) (
   input  logic clk,
   input  logic rst,
   vgroup_sequencer_if.slave bus,
   output logic lmul_stall,
   output logic illegal
);

   seq_state_t       state, state_nx;
   logic [REG_W-1:0] base_a, base_b, base_d;
   logic             widen_r, bscal_r, illegal_r;
   logic [4:0]       n_r;
   logic [3:0]       idx;
   logic [3:0]       off_a;
   logic [4:0]       dec_n;
   logic             dec_illegal;
   logic             accept, hs, at_last;

   vgroup_decode #(
      .VLEN     (VLEN),
      .MAX_LMUL (MAX_LMUL),
      .REG_W    (REG_W),
      .VL_W     (VL_W)
   ) u_decode (
      .raA      (bus.in_raA),
      .raB      (bus.in_raB),
      .rdest    (bus.in_rdest),
      .vlmul    (bus.in_vlmul),
      .vsew     (bus.in_vsew),
      .vl       (bus.in_vl),
      .widen    (bus.in_widen),
      .b_scalar (bus.in_b_scalar),
      .n        (dec_n),
      .illegal  (dec_illegal)
   );

   assign accept  = bus.in_valid && (state == IDLE);
   assign hs      = (state == ISSUE) && bus.uop_ready;
   assign at_last = ({1'b0, idx} == (n_r - 5'd1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:  if (accept && !dec_illegal && (dec_n != '0)) state_nx = ISSUE;
         ISSUE: if (hs && at_last) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         base_a    <= '0;
         base_b    <= '0;
         base_d    <= '0;
         widen_r   <= 1'b0;
         bscal_r   <= 1'b0;
         n_r       <= '0;
         idx       <= '0;
         illegal_r <= 1'b0;
      end else begin
         illegal_r <= accept && dec_illegal;
         if (accept) begin
            base_a  <= bus.in_raA;
            base_b  <= bus.in_raB;
            base_d  <= bus.in_rdest;
            widen_r <= bus.in_widen;
            bscal_r <= bus.in_b_scalar;
            n_r     <= dec_n;
            idx     <= '0;
         end else if (hs && !at_last) begin
            idx <= idx + 4'd1;
         end
      end
   end

   // Widening sources advance at half the destination rate.
   assign off_a = widen_r ? (idx >> 1) : idx;

   assign bus.in_ready  = (state == IDLE);
   assign bus.uop_valid = (state == ISSUE);
   assign bus.uop_idx   = idx;
   assign bus.uop_last  = (state == ISSUE) && at_last;
   assign bus.uop_raA   = base_a + REG_W'(off_a);
   assign bus.uop_raB   = bscal_r ? base_b : base_b + REG_W'(off_a);
   assign bus.uop_rdest = base_d + REG_W'(idx);
   assign lmul_stall    = (state == ISSUE);
   assign illegal       = illegal_r;

endmodule

// File: tb/tb_vgroup_sequencer.sv
// Scoreboard bench for vgroup_sequencer: expected micro-ops are predicted at
// send time and consumed as the DUT hands them off.
module tb_vgroup_sequencer;

   localparam int unsigned VLEN  = 128;
   localparam int unsigned REG_W = 5;
   localparam int unsigned VL_W  = 8;

   typedef struct {
      logic [4:0] ra;
      logic [4:0] rb;
      logic [4:0] rd;
      logic [3:0] idx;
      logic       last;
   } uop_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic lmul_stall, illegal;

   uop_t exp_q[$];
   int   checks = 0;
   int   failures = 0;
   int   stall_cycles = 0;

   always #5 clk = ~clk;

   vgroup_sequencer_if #(.REG_W(REG_W), .VL_W(VL_W)) bus();

   vgroup_sequencer #(
      .VLEN     (VLEN),
      .NREG     (32),
      .MAX_LMUL (8)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus.slave),
      .lmul_stall (lmul_stall),
      .illegal    (illegal)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Handshakes are sampled mid-cycle; the transfer completes on the next rising edge.
   always @(negedge clk) begin
      uop_t e;
      if (rst === 1'b0) begin
         if (lmul_stall) stall_cycles++;
         if (bus.uop_valid && bus.uop_ready) begin
            if (exp_q.size() == 0) begin
               check_eq("uop_unexpected", 1, 0);
            end else begin
               e = exp_q.pop_front();
               check_eq("uop_raA",   bus.uop_raA,   e.ra);
               check_eq("uop_raB",   bus.uop_raB,   e.rb);
               check_eq("uop_rdest", bus.uop_rdest, e.rd);
               check_eq("uop_idx",   bus.uop_idx,   e.idx);
               check_eq("uop_last",  bus.uop_last,  e.last);
            end
         end
      end
   end

   task automatic predict(input int ra, input int rb, input int rd, input int vlmul,
                          input int vsew, input int vl, input bit widen, input bit bsc,
                          output bit ill, output int n);
      int grp, emul, sew_bits, elems, nvl;
      ill = 1'b0;
      case (vlmul)
         0: grp = 1;
         1: grp = 2;
         2: grp = 4;
         3: grp = 8;
         4: begin grp = 1; ill = 1'b1; end
         default: grp = 1;
      endcase
      if (vsew > 3) ill = 1'b1;
      if (widen && (vlmul == 3 || vsew == 3)) ill = 1'b1;
      emul = widen ? 2 * grp : grp;
      if (ra % grp != 0) ill = 1'b1;
      if (!bsc && (rb % grp != 0)) ill = 1'b1;
      if (rd % emul != 0) ill = 1'b1;
      n = 0;
      if (!ill) begin
         sew_bits = 8 << vsew;
         if (widen) sew_bits = sew_bits * 2;
         elems = VLEN / sew_bits;
         nvl   = (vl + elems - 1) / elems;
         n     = (nvl < emul) ? nvl : emul;
      end
   endtask

   task automatic send(input int ra, input int rb, input int rd, input int vlmul,
                       input int vsew, input int vl, input bit widen, input bit bsc);
      bit   ill;
      int   n, t, off;
      uop_t u;
      predict(ra, rb, rd, vlmul, vsew, vl, widen, bsc, ill, n);
      @(posedge clk); #1;
      t = 0;
      while (!bus.in_ready && t < 200) begin
         @(posedge clk); #1;
         t++;
      end
      if (t >= 200) check_eq("in_ready_timeout", 0, 1);
      for (int i = 0; i < n; i++) begin
         off    = widen ? i / 2 : i;
         u.ra   = 5'(ra + off);
         u.rb   = bsc ? 5'(rb) : 5'(rb + off);
         u.rd   = 5'(rd + i);
         u.idx  = 4'(i);
         u.last = (i == n - 1);
         exp_q.push_back(u);
      end
      bus.in_raA      = 5'(ra);
      bus.in_raB      = 5'(rb);
      bus.in_rdest    = 5'(rd);
      bus.in_vlmul    = 3'(vlmul);
      bus.in_vsew     = 3'(vsew);
      bus.in_vl       = 8'(vl);
      bus.in_widen    = widen;
      bus.in_b_scalar = bsc;
      bus.in_valid    = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      check_eq("illegal_pulse", illegal, ill);
      if (ill || n == 0) begin
         check_eq("noissue_valid", bus.uop_valid, 0);
         check_eq("noissue_ready", bus.in_ready, 1);
      end
      if (ill) begin
         @(posedge clk); #1;
         check_eq("illegal_clear", illegal, 0);
      end
   endtask

   task automatic wait_drain();
      int t = 0;
      while ((exp_q.size() != 0 || !bus.in_ready) && t < 200) begin
         @(posedge clk); #1;
         t++;
      end
      if (t >= 200) check_eq("drain_timeout", 0, 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int s0;
      logic [4:0] snap;
      bus.in_valid = 1'b0; bus.in_raA = '0; bus.in_raB = '0; bus.in_rdest = '0;
      bus.in_vlmul = '0; bus.in_vsew = '0; bus.in_vl = '0;
      bus.in_widen = 1'b0; bus.in_b_scalar = 1'b0; bus.uop_ready = 1'b1;

      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_in_ready",   bus.in_ready,  1);
      check_eq("rst_uop_valid",  bus.uop_valid, 0);
      check_eq("rst_lmul_stall", lmul_stall,    0);
      check_eq("rst_illegal",    illegal,       0);
      check_eq("rst_uop_idx",    bus.uop_idx,   0);
      check_eq("rst_uop_raA",    bus.uop_raA,   0);
      check_eq("rst_uop_last",   bus.uop_last,  0);
      @(negedge clk) rst = 1'b0;

      // LMUL4 SEW32 vl16: four back-to-back micro-ops, one-cycle bubble after
      s0 = stall_cycles;
      send(8, 12, 4, 2, 2, 16, 0, 0);
      check_eq("t1_busy_start", bus.in_ready, 0);
      repeat (3) @(posedge clk);
      #1;
      check_eq("t1_busy_last", bus.in_ready, 0);
      @(posedge clk); #1;
      check_eq("t1_ready_after", bus.in_ready, 1);
      check_eq("t1_valid_after", bus.uop_valid, 0);
      check_eq("t1_stall_cycles", stall_cycles - s0, 4);
      check_eq("t1_all_issued", exp_q.size(), 0);

      send(16, 24, 0, 3, 0, 20, 0, 0);   // vl-limited: N=2
      wait_drain();
      send(2, 5, 8, 1, 1, 16, 1, 1);     // widening with scalar B
      wait_drain();
      send(3, 4, 2, 1, 0, 16, 0, 0);     // misaligned raA
      send(8, 12, 4, 2, 2, 0, 0, 0);     // vl=0
      send(0, 0, 0, 4, 0, 16, 0, 0);     // reserved vlmul
      send(0, 0, 0, 0, 4, 16, 0, 0);     // reserved vsew
      send(0, 0, 0, 0, 3, 16, 1, 0);     // widening at SEW64
      send(0, 0, 0, 3, 0, 16, 1, 0);     // widening at LMUL8
      send(2, 2, 2, 1, 0, 16, 1, 0);     // widened rdest misaligned
      send(3, 5, 7, 5, 2, 16, 0, 0);     // fractional LMUL
      wait_drain();
      send(4, 7, 8, 2, 1, 32, 0, 1);     // scalar B exempt from alignment
      wait_drain();
      send(0, 8, 16, 3, 0, 128, 0, 0);   // maximum vl, full LMUL8 group
      wait_drain();

      // Backpressure at idx 1
      send(4, 8, 12, 2, 2, 16, 0, 0);
      @(posedge clk); #1;
      check_eq("bp_idx_before", bus.uop_idx, 1);
      snap = bus.uop_raA;
      check_eq("bp_raA_before", snap, 5);
      bus.uop_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         check_eq("bp_idx_hold",   bus.uop_idx,   1);
         check_eq("bp_raA_hold",   bus.uop_raA,   snap);
         check_eq("bp_valid_hold", bus.uop_valid, 1);
      end
      bus.uop_ready = 1'b1;
      wait_drain();

      // Asynchronous reset at idx 2 of an LMUL8 group
      send(0, 8, 16, 3, 0, 128, 0, 0);
      repeat (2) @(posedge clk);
      #2;
      check_eq("rstmid_idx", bus.uop_idx, 2);
      rst = 1'b1;
      #1;
      check_eq("rstmid_valid",   bus.uop_valid, 0);
      check_eq("rstmid_stall",   lmul_stall,    0);
      check_eq("rstmid_illegal", illegal,       0);
      exp_q.delete();
      @(negedge clk) rst = 1'b0;
      @(posedge clk); #1;
      check_eq("rstmid_ready_after", bus.in_ready,  1);
      check_eq("rstmid_valid_after", bus.uop_valid, 0);
      send(8, 12, 4, 2, 2, 16, 0, 0);
      wait_drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
